// File: rtl/mini_seq_ctrl.sv
// mini_seq_ctrl: tiny instruction sequencer driving an add/sub accumulator.
// Each instruction is fetched into an instruction register and then
// executed in the following cycle. The controller supports single-step
// pausing, halt requests, a loop counter and conditional jumps.
module mini_seq_ctrl #(
  parameter int PC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              step_mode,
  input  logic              step,
  input  logic [PC_W+3:0]   inst,
  input  logic              acc_zero,
  output logic [PC_W-1:0]   pc,
  output logic              acc_en,
  output logic              acc_op,
  output logic              acc_clr,
  output logic [PC_W-1:0]   imm,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_CLR  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_LOOP = 4'h6;
  localparam logic [3:0] OP_LDC  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [PC_W-1:0] ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0] ZERO = {PC_W{1'b0}};

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   loop_q, loop_d;
  logic [PC_W+3:0]   ir_q, ir_d;

  logic [3:0]        opcode;
  logic [PC_W-1:0]   ir_imm;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   loop_dec;

  assign opcode   = ir_q[PC_W+3:PC_W];
  assign ir_imm   = ir_q[PC_W-1:0];
  assign pc_inc   = pc_q + ONE;
  assign loop_dec = loop_q - ONE;
  assign pc       = pc_q;

  // State, program counter, loop counter and instruction register flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= ZERO;
      loop_q  <= ZERO;
      ir_q    <= {(PC_W+4){1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      loop_q  <= loop_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state selection; the fetched instruction always executes before a halt is honoured.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !halt_req) state_d = ST_FETCH;
        else                    state_d = ST_IDLE;
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (opcode == OP_HALT) state_d = ST_DONE;
        else if (halt_req)     state_d = ST_IDLE;
        else if (step_mode)    state_d = ST_PAUSE;
        else                   state_d = ST_FETCH;
      end
      ST_PAUSE: begin
        if (halt_req)  state_d = ST_IDLE;
        else if (step) state_d = ST_FETCH;
        else           state_d = ST_PAUSE;
      end
      ST_DONE: begin
        if (start) state_d = ST_FETCH;
        else       state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction latch, pc and loop-counter updates; restart from DONE clears pc and counter.
  always_comb begin
    pc_d   = pc_q;
    loop_d = loop_q;
    ir_d   = ir_q;
    case (state_q)
      ST_FETCH: ir_d = inst;
      ST_EXEC: begin
        case (opcode)
          OP_HALT: pc_d = pc_q;
          OP_JMP:  pc_d = ir_imm;
          OP_JZ: begin
            if (acc_zero) pc_d = ir_imm;
            else          pc_d = pc_inc;
          end
          OP_LOOP: begin
            if (loop_q != ZERO) begin
              loop_d = loop_dec;
              if (loop_dec != ZERO) pc_d = ir_imm;
              else                  pc_d = pc_inc;
            end else begin
              pc_d = pc_inc;
            end
          end
          OP_LDC: begin
            loop_d = ir_imm;
            pc_d   = pc_inc;
          end
          default: pc_d = pc_inc;
        endcase
      end
      ST_DONE: begin
        if (start) begin
          pc_d   = ZERO;
          loop_d = ZERO;
        end else begin
          pc_d   = pc_q;
          loop_d = loop_q;
        end
      end
      default: begin
        pc_d   = pc_q;
        loop_d = loop_q;
      end
    endcase
  end

  // Datapath strobes and status, decoded only from registered state and instruction.
  always_comb begin
    acc_en  = 1'b0;
    acc_op  = 1'b0;
    acc_clr = 1'b0;
    imm     = ZERO;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_FETCH: busy = 1'b1;
      ST_PAUSE: busy = 1'b1;
      ST_EXEC: begin
        busy = 1'b1;
        imm  = ir_imm;
        case (opcode)
          OP_ADD: acc_en = 1'b1;
          OP_SUB: begin
            acc_en = 1'b1;
            acc_op = 1'b1;
          end
          OP_CLR: begin
            acc_en  = 1'b1;
            acc_clr = 1'b1;
          end
          default: acc_en = 1'b0;
        endcase
      end
      ST_DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mini_seq_ctrl.sv
// Directed self-checking bench for mini_seq_ctrl with a small program ROM model.
module tb_mini_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       halt_req = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic       acc_zero = 1'b0;
  logic [7:0] inst;
  logic [3:0] pc;
  logic       acc_en, acc_op, acc_clr;
  logic [3:0] imm;
  logic       busy, done;

  logic [7:0] mem [16];
  int n_checks = 0;
  int n_fail = 0;

  assign inst = mem[pc];

  mini_seq_ctrl #(.PC_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .step_mode(step_mode), .step(step), .inst(inst), .acc_zero(acc_zero),
    .pc(pc), .acc_en(acc_en), .acc_op(acc_op), .acc_clr(acc_clr),
    .imm(imm), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic test_reset();
    clear_mem();
    #3;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_checks++; if (pc !== 4'h0) begin n_fail++; $display("FAIL reset_pc: got %0h expected 0", pc); end
    n_checks++; if ({acc_en, acc_op, acc_clr, imm} !== 7'h00) begin n_fail++; $display("FAIL reset_strobes: got %0h expected 0", {acc_en, acc_op, acc_clr, imm}); end
    #9 rst = 1'b1;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start: got busy %0b expected 0", busy); end
  endtask

  // ADD 3, SUB 1, HALT
  task automatic test_add_sub_halt();
    int pulses = 0;
    clear_mem();
    mem[0] = 8'h13; mem[1] = 8'h21; mem[2] = 8'hF0;
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) begin
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fetch_busy: got %0b expected 1", busy); end
      end
      if (acc_en === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          n_checks++; if ({c[3:0], acc_op, imm} !== {4'd2, 1'b0, 4'd3}) begin n_fail++; $display("FAIL add_pulse: got cyc %0d op %0b imm %0d expected cyc 2 op 0 imm 3", c, acc_op, imm); end
        end else if (pulses == 2) begin
          n_checks++; if ({c[3:0], acc_op, imm} !== {4'd4, 1'b1, 4'd1}) begin n_fail++; $display("FAIL sub_pulse: got cyc %0d op %0b imm %0d expected cyc 4 op 1 imm 1", c, acc_op, imm); end
        end
      end else if (imm !== 4'h0) begin
        n_checks++; n_fail++; $display("FAIL imm_outside_exec: got %0h expected 0 at cyc %0d", imm, c);
      end
    end
    n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL add_sub_pulses: got %0d expected 2", pulses); end
    n_checks++; if ({done, busy, pc} !== {1'b1, 1'b0, 4'd2}) begin n_fail++; $display("FAIL halt_done: got done %0b busy %0b pc %0d expected 1 0 2", done, busy, pc); end
  endtask

  // LDC 3, ADD 1, LOOP 1, HALT started from DONE
  task automatic test_loop();
    int pulses = 0;
    int cyc = 0;
    clear_mem();
    mem[0] = 8'h73; mem[1] = 8'h11; mem[2] = 8'h61; mem[3] = 8'hF0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if ({busy, pc} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL restart_pc: got busy %0b pc %0d expected 1 0", busy, pc); end
    while (done !== 1'b1 && cyc < 40) begin
      if (acc_en === 1'b1) pulses++;
      tick();
      cyc++;
    end
    n_checks++; if (cyc >= 40) begin n_fail++; $display("FAIL loop_timeout: got %0d cycles expected under 40", cyc); end
    n_checks++; if (pulses !== 3) begin n_fail++; $display("FAIL loop_pulses: got %0d expected 3", pulses); end
    n_checks++; if (dut.loop_q !== 4'd0) begin n_fail++; $display("FAIL loop_counter: got %0d expected 0", dut.loop_q); end
    n_checks++; if (pc !== 4'd3) begin n_fail++; $display("FAIL loop_pc: got %0d expected 3", pc); end
  endtask

  // JZ taken/not taken, JMP and NOP wrap at pc=15, single-step pausing
  task automatic test_jumps_step();
    clear_mem();
    mem[0] = 8'h55;
    step_mode = 1'b1;
    acc_zero = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    n_checks++; if ({busy, pc} !== {1'b1, 4'd5}) begin n_fail++; $display("FAIL jz_taken: got busy %0b pc %0d expected 1 5", busy, pc); end
    tick(); tick();
    n_checks++; if ({busy, pc, acc_en} !== {1'b1, 4'd5, 1'b0}) begin n_fail++; $display("FAIL pause_hold: got busy %0b pc %0d en %0b expected 1 5 0", busy, pc, acc_en); end
    halt_req = 1'b1; step = 1'b1; tick(); halt_req = 1'b0; step = 1'b0;
    n_checks++; if ({busy, pc} !== {1'b0, 4'd5}) begin n_fail++; $display("FAIL pause_halt: got busy %0b pc %0d expected 0 5", busy, pc); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pause_halt_nofetch: got busy %0b expected 0", busy); end
    #2 rst = 1'b0; #1 rst = 1'b1;
    acc_zero = 1'b0;
    mem[1] = 8'h4F; mem[15] = 8'h40;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    n_checks++; if (pc !== 4'd1) begin n_fail++; $display("FAIL jz_not_taken: got %0d expected 1", pc); end
    step = 1'b1; tick(); step = 1'b0; tick(); tick();
    n_checks++; if (pc !== 4'd15) begin n_fail++; $display("FAIL jmp_to_15: got %0d expected 15", pc); end
    step = 1'b1; tick(); step = 1'b0; tick(); tick();
    n_checks++; if (pc !== 4'd0) begin n_fail++; $display("FAIL jmp_at_15: got %0d expected 0", pc); end
    mem[0] = 8'h4F; mem[15] = 8'h00;
    step = 1'b1; tick(); step = 1'b0; tick(); tick();
    step = 1'b1; tick(); step = 1'b0; tick(); tick();
    n_checks++; if ({busy, pc} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL nop_wrap: got busy %0b pc %0d expected 1 0", busy, pc); end
    halt_req = 1'b1; step = 1'b1; tick(); halt_req = 1'b0; step = 1'b0;
    step_mode = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL step_halt_idle: got busy %0b expected 0", busy); end
  endtask

  // halt_req raised during FETCH of ADD, then resume at next pc
  task automatic test_halt_in_fetch();
    clear_mem();
    mem[0] = 8'h12; mem[1] = 8'h21; mem[2] = 8'hF0;
    start = 1'b1; tick(); start = 1'b0;
    halt_req = 1'b1;
    tick();
    n_checks++; if ({acc_en, acc_op, imm} !== {1'b1, 1'b0, 4'd2}) begin n_fail++; $display("FAIL halt_fetch_add: got en %0b op %0b imm %0d expected 1 0 2", acc_en, acc_op, imm); end
    tick();
    halt_req = 1'b0;
    n_checks++; if ({busy, acc_en, pc} !== {1'b0, 1'b0, 4'd1}) begin n_fail++; $display("FAIL halt_fetch_idle: got busy %0b en %0b pc %0d expected 0 0 1", busy, acc_en, pc); end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_checks++; if ({acc_en, acc_op, imm} !== {1'b1, 1'b1, 4'd1}) begin n_fail++; $display("FAIL resume_sub: got en %0b op %0b imm %0d expected 1 1 1", acc_en, acc_op, imm); end
    tick(); tick(); tick();
    n_checks++; if ({done, pc} !== {1'b1, 4'd2}) begin n_fail++; $display("FAIL resume_done: got done %0b pc %0d expected 1 2", done, pc); end
  endtask

  // asynchronous reset asserted in the middle of an EXEC cycle
  task automatic test_reset_in_exec();
    int stray = 0;
    clear_mem();
    mem[0] = 8'h31; mem[1] = 8'h11; mem[2] = 8'hF0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_checks++; if ({acc_en, acc_clr} !== 2'b11) begin n_fail++; $display("FAIL clr_strobe: got en %0b clr %0b expected 1 1", acc_en, acc_clr); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({acc_en, acc_op, acc_clr, imm, busy, done, pc} !== 13'h0) begin n_fail++; $display("FAIL async_reset: got %0h expected 0", {acc_en, acc_op, acc_clr, imm, busy, done, pc}); end
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (acc_en === 1'b1 || busy === 1'b1) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL post_reset_quiet: got %0d active cycles expected 0", stray); end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_checks++; if ({acc_en, acc_clr, imm} !== {1'b1, 1'b1, 4'd1}) begin n_fail++; $display("FAIL restart_from_0: got en %0b clr %0b imm %0d expected 1 1 1", acc_en, acc_clr, imm); end
  endtask

  initial begin
    test_reset();
    test_add_sub_halt();
    test_loop();
    test_jumps_step();
    test_halt_in_fetch();
    test_reset_in_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
